load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_lane_align.sv | 60 ++++++
 rtl/load_store_unit.sv | 133 +++++++++++++
 tb/tb_load_store_unit.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the RV32I funct3 width/sign codes, the FSM state encoding and the
// request legality check used when a request is accepted.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        MERGE   = 3'd3,
        WRITE   = 3'd4,
        RESP    = 3'd5
    } state_t;

    // A request faults on an unknown width code, on unsigned widths used
    // for a store (they only make sense for loads), or on misalignment.
    function automatic logic is_fault(input logic       we,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
        case (funct3)
            F3_B:    is_fault = 1'b0;
            F3_H:    is_fault = addr_lo[0];
            F3_W:    is_fault = (addr_lo != 2'b00);
            F3_BU:   is_fault = we;
            F3_HU:   is_fault = we | addr_lo[0];
            default: is_fault = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic for the load/store unit.
// Ports:
//   funct3     - width/sign code of the current access
//   addr_lo    - byte offset within the word
//   rdata      - word read from memory
//   wdata      - right-aligned store data (low half is all a sub-word store uses)
//   load_data  - selected lane of rdata, sign/zero extended
//   merge_data - rdata with the addressed byte/half replaced by wdata
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection: bytes by the full offset, halves by offset bit 1.
    always_comb begin
        byte_sel = 8'h00;
        case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Load extension; W (and anything else, which never reaches here
    // because it faults first) passes the word through.
    always_comb begin
        load_data = rdata;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h000000, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0000, half_sel};
            default: load_data = rdata;
        endcase
    end

    // Read-modify-write merge: every byte outside the addressed lane is
    // copied from rdata unchanged.
    always_comb begin
        merge_data = rdata;
        if (funct3 == F3_B) begin
            merge_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
        end else if (funct3 == F3_H) begin
            merge_data[{addr_lo[1], 4'b0000} +: 16] = wdata;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a core request port and a word-wide memory.
// Ports:
//   clk, rst                 - clock and asynchronous active-high reset
//   req_valid/req_ready      - request handshake (ready only in IDLE)
//   req_we, req_funct3       - store/load select and width/sign code
//   req_addr, req_wdata      - byte address and right-aligned store data
//   resp_valid               - one-cycle completion pulse
//   resp_rdata, resp_fault   - extended load result and fault flag
//   mem_address              - word-aligned memory address
//   mem_read, mem_write      - memory strobes, decoded from state only
//   mem_wdata, mem_rdata     - memory write word and read word
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_fault,
    output logic [AW-1:0] mem_address,
    output logic          mem_read,
    output logic          mem_write,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_t      state;
    state_t      next_state;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [15:0] r_wdata_lo;
    logic        accept;
    logic        req_fault;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign accept    = req_valid && (state == IDLE);
    assign req_fault = is_fault(req_we, req_funct3, req_addr[1:0]);

    // Handshake and strobes come straight from the state register so no
    // request input can reach them combinationally.
    assign req_ready  = (state == IDLE);
    assign mem_read   = (state == READ);
    assign mem_write  = (state == WRITE);
    assign resp_valid = (state == RESP);

    lsu_lane_align u_lane_align (
        .funct3     (r_funct3),
        .addr_lo    (r_addr_lo),
        .rdata      (mem_rdata),
        .wdata      (r_wdata_lo),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Faults skip memory entirely; word stores skip the read; sub-word
    // stores read the word first so the untouched bytes survive.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_fault) begin
                        next_state = RESP;
                    end else if (req_we && (req_funct3 == F3_W)) begin
                        next_state = WRITE;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            READ:    next_state = r_we ? MERGE : CAPTURE;
            CAPTURE: next_state = RESP;
            MERGE:   next_state = WRITE;
            WRITE:   next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request capture and result registers. resp_rdata is cleared on
    // acceptance so stores and faults report zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_addr_lo   <= 2'b00;
            r_wdata_lo  <= 16'h0000;
            mem_address <= '0;
            mem_wdata   <= '0;
            resp_rdata  <= '0;
            resp_fault  <= 1'b0;
        end else begin
            if (accept) begin
                r_we        <= req_we;
                r_funct3    <= req_funct3;
                r_addr_lo   <= req_addr[1:0];
                r_wdata_lo  <= req_wdata[15:0];
                mem_address <= {req_addr[AW-1:2], 2'b00};
                resp_rdata  <= '0;
                resp_fault  <= req_fault;
                if (req_we) begin
                    mem_wdata <= req_wdata;
                end
            end
            if (state == CAPTURE) begin
                resp_rdata <= load_data;
            end
            if (state == MERGE) begin
                mem_wdata <= merge_data;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small
// synchronous word memory model behind the memory port.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:15];
    logic        mem_init;
    int          rd_count;
    int          wr_count;
    int          resp_count;
    int          acc_count;
    int          excl_viol;
    logic [31:0] last_wr_addr;
    logic [31:0] last_wr_data;

    int errors;
    int checks;

    load_store_unit #(.AW(32), .DW(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_fault  (resp_fault),
        .mem_address (mem_address),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word 0 is 0x1000, word 1 is 0x1004. Read data appears
    // the cycle after a read strobe and holds until the next read.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h12347F80;
        end else begin
            if (mem_read) begin
                mem_rdata <= mem[mem_address[5:2]];
                rd_count++;
            end
            if (mem_write) begin
                mem[mem_address[5:2]] <= mem_wdata;
                last_wr_addr <= mem_address;
                last_wr_data <= mem_wdata;
                wr_count++;
            end
        end
        if (resp_valid) resp_count++;
        if (req_valid && req_ready) acc_count++;
        if (mem_read && mem_write) excl_viol++;
    end

    // Issue one request and wait for its response pulse. lat is the number
    // of cycles from acceptance to resp_valid, or -1 on timeout.
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata,
                          output logic fault, output int nrd, output int nwr);
        int rd0;
        int wr0;
        int tries;
        lat = -1;
        rdata = 32'hx;
        fault = 1'bx;
        @(negedge clk);
        tries = 0;
        while (!req_ready && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        rd0 = rd_count;
        wr0 = wr_count;
        req_valid = 1'b1;
        req_we = we;
        req_funct3 = f3;
        req_addr = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = c;
                break;
            end
        end
        rdata = resp_rdata;
        fault = resp_fault;
        nrd = rd_count - rd0;
        nwr = wr_count - wr0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=1", req_ready); end
        checks++;
        if (resp_valid !== 1'b0 || resp_fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp got valid=%b fault=%b exp=0/0", resp_valid, resp_fault); end
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobes got rd=%b wr=%b exp=0/0", mem_read, mem_write); end
        checks++;
        if (mem_address !== 32'h0 || mem_wdata !== 32'h0 || resp_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_regs got addr=%h wdata=%h rdata=%h exp=0", mem_address, mem_wdata, resp_rdata);
        end
    endtask

    task automatic test_loads();
        int lat; logic [31:0] rd; logic f; int nr; int nw;
        do_req(1'b0, 3'b010, 32'h1000, 32'h0, lat, rd, f, nr, nw);
        checks++;
        if (rd !== 32'h12347F80 || lat != 3) begin errors++; $display("[TB] FAIL lw_1000 got=%h lat=%0d exp=12347f80 lat=3", rd, lat); end
        checks++;
        if (nr != 1 || nw != 0 || f !== 1'b0) begin errors++; $display("[TB] FAIL lw_strobes got rd=%0d wr=%0d fault=%b exp=1/0/0", nr, nw, f); end
        do_req(1'b0, 3'b000, 32'h1000, 32'h0, lat, rd, f, nr, nw);
        checks++;
        if (rd !== 32'hFFFFFF80) begin errors++; $display("[TB] FAIL lb_1000 got=%h exp=ffffff80", rd); end
        do_req(1'b0, 3'b100, 32'h1000, 32'h0, lat, rd, f, nr, nw);
        checks++;
        if (rd !== 32'h00000080) begin errors++; $display("[TB] FAIL lbu_1000 got=%h exp=00000080", rd); end
        do_req(1'b0, 3'b000, 32'h1001, 32'h0, lat, rd, f, nr, nw);
        checks++;
        if (rd !== 32'h0000007F) begin errors++; $display("[TB] FAIL lb_1001 got=%h exp=0000007f", rd); end
        do_req(1'b0, 3'b001, 32'h1002, 32'h0, lat, rd, f, nr, nw);
        checks++;
        if (rd !== 32'h00001234) begin errors++; $display("[TB] FAIL lh_1002 got=%h exp=00001234", rd); end
    endtask

    task automatic test_store_byte();
        int lat; logic [31:0] rd; logic f; int nr; int nw;
        do_req(1'b1, 3'b000, 32'h1001, 32'h000000AA, lat, rd, f, nr, nw);
        checks++;
        if (nr != 1 || nw != 1) begin errors++; $display("[TB] FAIL sb_strobes got rd=%0d wr=%0d exp=1/1", nr, nw); end
        checks++;
        if (last_wr_data !== 32'h1234AA80 || last_wr_addr !== 32'h1000) begin
            errors++;
            $display("[TB] FAIL sb_word got=%h@%h exp=1234aa80@00001000", last_wr_data, last_wr_addr);
        end
        checks++;
        if (lat != 4 || rd !== 32'h0 || f !== 1'b0) begin errors++; $display("[TB] FAIL sb_resp got lat=%0d rdata=%h fault=%b exp=4/0/0", lat, rd, f); end
        do_req(1'b0, 3'b010, 32'h1000, 32'h0, lat, rd, f, nr, nw);
        checks++;
        if (rd !== 32'h1234AA80) begin errors++; $display("[TB] FAIL lw_after_sb got=%h exp=1234aa80", rd); end
    endtask

    task automatic test_store_word();
        int lat; logic [31:0] rd; logic f; int nr; int nw;
        do_req(1'b1, 3'b010, 32'h1004, 32'hDEADBEEF, lat, rd, f, nr, nw);
        checks++;
        if (last_wr_addr !== 32'h1004 || last_wr_data !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL sw_word got=%h@%h exp=deadbeef@00001004", last_wr_data, last_wr_addr);
        end
        checks++;
        if (lat != 2 || nr != 0 || nw != 1) begin errors++; $display("[TB] FAIL sw_timing got lat=%0d rd=%0d wr=%0d exp=2/0/1", lat, nr, nw); end
        do_req(1'b0, 3'b101, 32'h1006, 32'h0, lat, rd, f, nr, nw);
        checks++;
        if (rd !== 32'h0000DEAD) begin errors++; $display("[TB] FAIL lhu_1006 got=%h exp=0000dead", rd); end
        do_req(1'b0, 3'b001, 32'h1006, 32'h0, lat, rd, f, nr, nw);
        checks++;
        if (rd !== 32'hFFFFDEAD) begin errors++; $display("[TB] FAIL lh_1006 got=%h exp=ffffdead", rd); end
    endtask

    task automatic test_faults();
        int lat; logic [31:0] rd; logic f; int nr; int nw;
        do_req(1'b0, 3'b010, 32'h1002, 32'h0, lat, rd, f, nr, nw);
        checks++;
        if (f !== 1'b1 || rd !== 32'h0 || nr != 0 || nw != 0 || lat != 1) begin
            errors++;
            $display("[TB] FAIL lw_misalign got fault=%b rdata=%h rd=%0d wr=%0d lat=%0d exp=1/0/0/0/1", f, rd, nr, nw, lat);
        end
        do_req(1'b0, 3'b001, 32'h1001, 32'h0, lat, rd, f, nr, nw);
        checks++;
        if (f !== 1'b1 || rd !== 32'h0 || nr != 0 || nw != 0) begin
            errors++;
            $display("[TB] FAIL lh_misalign got fault=%b rdata=%h rd=%0d wr=%0d exp=1/0/0/0", f, rd, nr, nw);
        end
        do_req(1'b0, 3'b011, 32'h1000, 32'h0, lat, rd, f, nr, nw);
        checks++;
        if (f !== 1'b1 || nr != 0 || nw != 0) begin errors++; $display("[TB] FAIL f3_011 got fault=%b rd=%0d wr=%0d exp=1/0/0", f, nr, nw); end
        do_req(1'b1, 3'b100, 32'h1000, 32'h55, lat, rd, f, nr, nw);
        checks++;
        if (f !== 1'b1 || nr != 0 || nw != 0) begin errors++; $display("[TB] FAIL sbu_illegal got fault=%b rd=%0d wr=%0d exp=1/0/0", f, nr, nw); end
        do_req(1'b0, 3'b000, 32'h1003, 32'h0, lat, rd, f, nr, nw);
        checks++;
        if (f !== 1'b0 || rd !== 32'h00000012) begin errors++; $display("[TB] FAIL lb_1003 got fault=%b rdata=%h exp=0/00000012", f, rd); end
    endtask

    task automatic test_reset_mid_write();
        int wr0; int rs0;
        int lat; logic [31:0] rd; logic f; int nr; int nw;
        @(negedge clk);
        wr0 = wr_count;
        rs0 = resp_count;
        req_valid = 1'b1;
        req_we = 1'b1;
        req_funct3 = 3'b001;
        req_addr = 32'h1004;
        req_wdata = 32'h00005555;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (mem_write !== 1'b1) begin errors++; $display("[TB] FAIL sh_reach_write got mem_write=%b exp=1", mem_write); end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_async got wr=%b resp=%b exp=0/0", mem_write, resp_valid); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wr_count != wr0 || resp_count != rs0) begin
            errors++;
            $display("[TB] FAIL rst_abort got writes=%0d resps=%0d exp=0/0", wr_count - wr0, resp_count - rs0);
        end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready got=%b exp=1", req_ready); end
        checks++;
        if (mem[1] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rst_mem got=%h exp=deadbeef", mem[1]); end
        do_req(1'b0, 3'b010, 32'h1004, 32'h0, lat, rd, f, nr, nw);
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL lw_after_rst got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_back_to_back();
        int acc0; int rd0; int rs0;
        @(negedge clk);
        acc0 = acc_count;
        rd0 = rd_count;
        rs0 = resp_count;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_funct3 = 3'b010;
        req_addr = 32'h1000;
        req_wdata = 32'h0;
        // Each load occupies IDLE, READ, CAPTURE, RESP: ready every 4th cycle.
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (req_ready !== ((k % 4) == 0)) begin
                errors++;
                $display("[TB] FAIL b2b_ready[%0d] got=%b exp=%b", k, req_ready, ((k % 4) == 0));
            end
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (acc_count - acc0 != 5 || resp_count - rs0 != 5 || rd_count - rd0 != 5) begin
            errors++;
            $display("[TB] FAIL b2b_counts got acc=%0d resp=%0d rd=%0d exp=5/5/5", acc_count - acc0, resp_count - rs0, rd_count - rd0);
        end
        checks++;
        if (resp_rdata !== 32'h1234AA80) begin errors++; $display("[TB] FAIL b2b_rdata got=%h exp=1234aa80", resp_rdata); end
        checks++;
        if (excl_viol != 0) begin errors++; $display("[TB] FAIL strobe_exclusive got=%0d exp=0", excl_viol); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rd_count = 0;
        wr_count = 0;
        resp_count = 0;
        acc_count = 0;
        excl_viol = 0;
        last_wr_addr = 32'h0;
        last_wr_data = 32'h0;
        mem_rdata = 32'h0;
        rst = 1'b1;
        mem_init = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = 3'b000;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        @(posedge clk);
        test_reset();
        mem_init = 1'b0;
        rst = 1'b0;
        test_loads();
        test_store_byte();
        test_store_word();
        test_faults();
        test_reset_mid_write();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
